// File: rtl/sme_pkg.sv
// Shared definitions for the SME feeder: control byte codes, size defaults,
// FSM state and frame type enums, and a byte classifier.
package sme_pkg;

   localparam logic [7:0] CTRL_END = 8'h00;
   localparam logic [7:0] CTRL_STR = 8'h01;
   localparam logic [7:0] CTRL_PAT = 8'h02;

   localparam int STR_MAX_DEF = 32;
   localparam int PAT_MAX_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_BURST,
      ST_WAIT
   } state_t;

   typedef enum logic {
      FRM_STR,
      FRM_PAT
   } frame_t;

   typedef enum logic [1:0] {
      BYTE_DATA,
      BYTE_STR,
      BYTE_PAT,
      BYTE_END
   } byte_kind_t;

   function automatic byte_kind_t classify(input logic [7:0] b);
      case (b)
         CTRL_END: return BYTE_END;
         CTRL_STR: return BYTE_STR;
         CTRL_PAT: return BYTE_PAT;
         default:  return BYTE_DATA;
      endcase
   endfunction

endpackage

// File: rtl/sme_frame_buf.sv
// Frame buffer for the SME feeder: DEPTH x 8 register file, one synchronous
// write port and one combinational read port. Pointers live in the feeder.
module sme_frame_buf #(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   // NOTE: storage is not reset; the feeder's count defines which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sme_feeder.sv
// Framing stage in front of the SME: parses header/end bytes, buffers a frame,
// replays it as a gap-free burst. Optional WAIT watchdog: SME_FEEDER_TIMEOUT_EN.
module sme_feeder
   import sme_pkg::*;
#(
   parameter int STR_MAX     = STR_MAX_DEF,
   parameter int PAT_MAX     = PAT_MAX_DEF,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   input  logic       sme_valid,
   output logic       err
);

   localparam int AW = $clog2(STR_MAX);
   localparam int CW = AW + 1;

   state_t        state, state_next;
   frame_t        ftype;
   byte_kind_t    kind;
   logic [CW-1:0] count;
   logic [CW-1:0] limit;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_addr;
   logic [7:0]    buf_rd_data;
   logic          ovf, have_str;
   logic          take, is_hdr, at_limit, end_ok, last_byte, timeout;
   logic          wr_en, err_next;

   assign kind      = classify(in_data);
   assign take      = in_valid && in_ready;
   assign is_hdr    = (kind == BYTE_STR) || (kind == BYTE_PAT);
   assign limit     = (ftype == FRM_STR) ? CW'(STR_MAX) : CW'(PAT_MAX);
   assign at_limit  = count >= limit;
   assign end_ok    = (count != '0) && ((ftype == FRM_STR) || have_str);
   assign last_byte = ({1'b0, rd_ptr} + CW'(1)) == count;
   assign rd_addr   = (state == ST_BURST) ? rd_ptr + AW'(1) : '0;
   assign in_ready  = (state == ST_IDLE) || (state == ST_COLLECT);

   sme_frame_buf #(.DEPTH(STR_MAX), .AW(AW)) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (count[AW-1:0]),
      .wr_data (in_data),
      .rd_addr (rd_addr),
      .rd_data (buf_rd_data)
   );

`ifdef SME_FEEDER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] wait_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 wait_cnt <= '0;
      else if (state != ST_WAIT) wait_cnt <= '0;
      else                       wait_cnt <= wait_cnt + TW'(1);
   end

   assign timeout = (state == ST_WAIT) && !sme_valid && (wait_cnt == WAIT_LAST);
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC != 0);
   assign timeout        = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (take && is_hdr) state_next = ST_COLLECT;
         ST_COLLECT: if (take && kind == BYTE_END) state_next = end_ok ? ST_BURST : ST_IDLE;
         ST_BURST:   if (last_byte) state_next = (ftype == FRM_STR) ? ST_IDLE : ST_WAIT;
         ST_WAIT:    if (sme_valid || timeout) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      // NOTE: defaults first, so no path through the case leaves a latch behind.
      wr_en    = 1'b0;
      err_next = 1'b0;
      case (state)
         ST_IDLE: err_next = take && (kind == BYTE_DATA);
         ST_COLLECT: begin
            if (take) begin
               case (kind)
                  BYTE_DATA: begin
                     wr_en    = !at_limit;
                     err_next = at_limit && !ovf;
                  end
                  BYTE_END: err_next = !end_ok;
                  default:  err_next = 1'b1;
               endcase
            end
         end
         ST_WAIT: err_next = timeout;
         default: ;
      endcase
   end

   // Frame bookkeeping and registered SME outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ftype     <= FRM_STR;
         count     <= '0;
         ovf       <= 1'b0;
         rd_ptr    <= '0;
         have_str  <= 1'b0;
         chardata  <= '0;
         isstring  <= 1'b0;
         ispattern <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= err_next;

         if (take && is_hdr) begin
            ftype <= (kind == BYTE_PAT) ? FRM_PAT : FRM_STR;
            count <= '0;
            ovf   <= 1'b0;
         end else if (wr_en) begin
            count <= count + CW'(1);
         end else if (state == ST_COLLECT && take && kind == BYTE_DATA) begin
            ovf <= 1'b1;
         end

         if (state == ST_COLLECT && state_next == ST_BURST) begin
            chardata  <= buf_rd_data;
            isstring  <= (ftype == FRM_STR);
            ispattern <= (ftype == FRM_PAT);
            rd_ptr    <= '0;
         end else if (state == ST_BURST) begin
            if (last_byte) begin
               chardata  <= '0;
               isstring  <= 1'b0;
               ispattern <= 1'b0;
               if (ftype == FRM_STR) have_str <= 1'b1;
            end else begin
               chardata <= buf_rd_data;
               rd_ptr   <= rd_ptr + AW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: inputs change and outputs are sampled on the
// falling clock edge; expected values are hand-derived cycle by cycle.
module tb_sme_feeder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] chardata;
   logic       isstring;
   logic       ispattern;
   logic       sme_valid;
   logic       err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sme_feeder dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .chardata  (chardata),
      .isstring  (isstring),
      .ispattern (ispattern),
      .sme_valid (sme_valid),
      .err       (err)
   );

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
      end
   endtask

   task automatic expect_out(input string tag, input logic [7:0] cd, input logic is,
                             input logic ip, input logic rdy, input logic er);
      check({tag, ".chardata"},  chardata,  cd);
      check({tag, ".isstring"},  isstring,  is);
      check({tag, ".ispattern"}, ispattern, ip);
      check({tag, ".in_ready"},  in_ready,  rdy);
      check({tag, ".err"},       err,       er);
   endtask

   task automatic drive(input logic v, input logic [7:0] d);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
   endtask

   task automatic idle_cycle();
      drive(1'b0, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; sme_valid = 1'b0;
      repeat (2) @(negedge clk);
      expect_out("reset", 8'h00, 0, 0, 1, 0);
      reset = 1'b0;

      // Pattern before any string: dropped with one err, SME untouched.
      drive(1, 8'h02); expect_out("nostr_hdr", 8'h00, 0, 0, 1, 0);
      drive(1, 8'h58);
      drive(1, 8'h00);
      idle_cycle(); expect_out("nostr_end", 8'h00, 0, 0, 1, 1);
      idle_cycle(); expect_out("nostr_after", 8'h00, 0, 0, 1, 0);

      // Data byte in IDLE errs; stray end byte does not; empty frame errs.
      drive(1, 8'h55); idle_cycle(); expect_out("idle_data", 8'h00, 0, 0, 1, 1);
      drive(1, 8'h00); idle_cycle(); expect_out("idle_end", 8'h00, 0, 0, 1, 0);
      drive(1, 8'h01); drive(1, 8'h00);
      idle_cycle(); expect_out("empty_frame", 8'h00, 0, 0, 1, 1);

      // String "ABC".
      drive(1, 8'h01); drive(1, 8'h41); drive(1, 8'h42); drive(1, 8'h43); drive(1, 8'h00);
      idle_cycle(); expect_out("str_b0", 8'h41, 1, 0, 0, 0);
      idle_cycle(); expect_out("str_b1", 8'h42, 1, 0, 0, 0);
      idle_cycle(); expect_out("str_b2", 8'h43, 1, 0, 0, 0);
      idle_cycle(); expect_out("str_done", 8'h00, 0, 0, 1, 0);

      // sme_valid outside WAIT has no effect.
      @(negedge clk); sme_valid = 1'b1;
      @(negedge clk); sme_valid = 1'b0;
      expect_out("stray_valid", 8'h00, 0, 0, 1, 0);

      // Pattern "BC", then hold until sme_valid.
      drive(1, 8'h02); drive(1, 8'h42); drive(1, 8'h43); drive(1, 8'h00);
      idle_cycle(); expect_out("pat_b0", 8'h42, 0, 1, 0, 0);
      idle_cycle(); expect_out("pat_b1", 8'h43, 0, 1, 0, 0);
      idle_cycle(); expect_out("pat_wait", 8'h00, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         idle_cycle(); check("pat_hold.in_ready", in_ready, 1'b0);
      end
      @(negedge clk); sme_valid = 1'b1;
      check("pat_valid.in_ready", in_ready, 1'b0);
      @(negedge clk); sme_valid = 1'b0;
      expect_out("pat_release", 8'h00, 0, 0, 1, 0);

      // Header inside a frame aborts it; new pattern 'Q' is replayed.
      drive(1, 8'h01); drive(1, 8'h41); drive(1, 8'h02);
      drive(1, 8'h51); check("abort.err", err, 1'b1);
      drive(1, 8'h00); check("abort_next.err", err, 1'b0);
      idle_cycle(); expect_out("abort_b0", 8'h51, 0, 1, 0, 0);
      idle_cycle(); expect_out("abort_wait", 8'h00, 0, 0, 0, 0);
      @(negedge clk); sme_valid = 1'b1;
      @(negedge clk); sme_valid = 1'b0;
      expect_out("abort_release", 8'h00, 0, 0, 1, 0);

      // 40-byte string: first 32 kept, a single err on the 33rd byte.
      drive(1, 8'h01);
      for (int i = 0; i < 40; i++) begin
         drive(1, 8'(32 + i));
         check("ovf_collect.err", err, (i == 33));
      end
      drive(1, 8'h00); check("ovf_last.err", err, 1'b0);
      for (int j = 0; j < 32; j++) begin
         idle_cycle(); expect_out("ovf_burst", 8'(32 + j), 1, 0, 0, 0);
      end
      idle_cycle(); expect_out("ovf_done", 8'h00, 0, 0, 1, 0);

      // Reset mid-burst cuts outputs and forgets the loaded string.
      drive(1, 8'h01); drive(1, 8'h61); drive(1, 8'h62); drive(1, 8'h63); drive(1, 8'h64);
      drive(1, 8'h00);
      idle_cycle(); expect_out("rst_b0", 8'h61, 1, 0, 0, 0);
      idle_cycle(); expect_out("rst_b1", 8'h62, 1, 0, 0, 0);
      #1 reset = 1'b1;
      #1 expect_out("rst_mid", 8'h00, 0, 0, 1, 0);
      @(negedge clk); reset = 1'b0;
      drive(1, 8'h02); drive(1, 8'h41); drive(1, 8'h00);
      idle_cycle(); expect_out("rst_nostr", 8'h00, 0, 0, 1, 1);
      idle_cycle(); expect_out("rst_idle", 8'h00, 0, 0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
